// File: rtl/idex_operand_stage_if.sv
// Bundle between decode/regfile/forwarding sources and the ID/EX operand stage.
// With IDEX_PERF_EN defined the bundle also carries the bubble/hold counters.
interface idex_operand_stage_if #(
    parameter int unsigned W      = 32,
    parameter int unsigned CTRL_W = 8
);
    // decode slot
    logic              d_valid;
    logic [4:0]        d_rs;
    logic [4:0]        d_rt;
    logic              d_uses_rs;
    logic              d_uses_rt;
    logic [4:0]        d_wn;
    logic              d_wreg;
    logic              d_m2reg;
    logic [W-1:0]      d_imm;
    logic [CTRL_W-1:0] d_ctrl;
    // register file read port
    logic [4:0]        rna;
    logic [4:0]        rnb;
    logic [W-1:0]      qa;
    logic [W-1:0]      qb;
    // forwarding sources
    logic [W-1:0]      e_alu;
    logic [4:0]        m_wn;
    logic              m_wreg;
    logic              m_m2reg;
    logic [W-1:0]      m_alu;
    logic [W-1:0]      m_mdata;
    logic [4:0]        w_wn;
    logic              w_we;
    logic [W-1:0]      w_d;
    // pipeline control
    logic              flush;
    logic              e_hold;
    logic              stall;
    // EX-stage register
    logic              e_valid;
    logic              e_wreg;
    logic              e_m2reg;
    logic [4:0]        e_wn;
    logic [W-1:0]      e_a;
    logic [W-1:0]      e_b;
    logic [W-1:0]      e_imm;
    logic [CTRL_W-1:0] e_ctrl;
`ifdef IDEX_PERF_EN
    logic [31:0]       bubble_cnt;
    logic [31:0]       hold_cnt;
`endif

    // driver side: decode, regfile, later stages
    modport master (
        output d_valid, d_rs, d_rt, d_uses_rs, d_uses_rt, d_wn, d_wreg, d_m2reg,
               d_imm, d_ctrl, qa, qb, e_alu, m_wn, m_wreg, m_m2reg, m_alu,
               m_mdata, w_wn, w_we, w_d, flush, e_hold,
        input  rna, rnb, stall, e_valid, e_wreg, e_m2reg, e_wn, e_a, e_b,
               e_imm, e_ctrl
`ifdef IDEX_PERF_EN
        , input bubble_cnt, hold_cnt
`endif
    );

    // operand stage side
    modport slave (
        input  d_valid, d_rs, d_rt, d_uses_rs, d_uses_rt, d_wn, d_wreg, d_m2reg,
               d_imm, d_ctrl, qa, qb, e_alu, m_wn, m_wreg, m_m2reg, m_alu,
               m_mdata, w_wn, w_we, w_d, flush, e_hold,
        output rna, rnb, stall, e_valid, e_wreg, e_m2reg, e_wn, e_a, e_b,
               e_imm, e_ctrl
`ifdef IDEX_PERF_EN
        , output bubble_cnt, hold_cnt
`endif
    );
endinterface

// File: rtl/idex_operand_stage.sv
// Operand fetch, EX/MEM/WB forwarding, load-use bubble and ID/EX register.
// Optional feature macro: IDEX_PERF_EN adds saturating bubble/hold counters.
module idex_operand_stage #(
    parameter int unsigned W      = 32,
    parameter int unsigned CTRL_W = 8
) (
    input  logic clk,
    input  logic clrn,
    idex_operand_stage_if.slave bus
);

    logic         ex_fwd;
    logic [W-1:0] m_res;
    logic [W-1:0] fwd_a;
    logic [W-1:0] fwd_b;
    logic         load_use;
    logic         kill;

    // regfile addresses come straight from decode
    assign bus.rna = bus.d_rs;
    assign bus.rnb = bus.d_rt;

    // EX can only forward a non-load result; MEM picks load data for loads
    assign ex_fwd = bus.e_valid & bus.e_wreg & ~bus.e_m2reg;
    assign m_res  = bus.m_m2reg ? bus.m_mdata : bus.m_alu;

    // operand A: r0, then youngest producer first, then regfile
    always_comb begin
        fwd_a = bus.qa;
        if (bus.d_rs == 5'd0)                         fwd_a = '0;
        else if (ex_fwd && bus.e_wn == bus.d_rs)      fwd_a = bus.e_alu;
        else if (bus.m_wreg && bus.m_wn == bus.d_rs)  fwd_a = m_res;
        else if (bus.w_we && bus.w_wn == bus.d_rs)    fwd_a = bus.w_d;
    end

    // operand B: same priority on rt
    always_comb begin
        fwd_b = bus.qb;
        if (bus.d_rt == 5'd0)                         fwd_b = '0;
        else if (ex_fwd && bus.e_wn == bus.d_rt)      fwd_b = bus.e_alu;
        else if (bus.m_wreg && bus.m_wn == bus.d_rt)  fwd_b = m_res;
        else if (bus.w_we && bus.w_wn == bus.d_rt)    fwd_b = bus.w_d;
    end

    // load in EX whose data a valid decode needs: one bubble
    always_comb begin
        load_use = bus.d_valid & bus.e_valid & bus.e_wreg & bus.e_m2reg
                 & (bus.e_wn != 5'd0)
                 & ((bus.d_uses_rs & (bus.e_wn == bus.d_rs))
                  | (bus.d_uses_rt & (bus.e_wn == bus.d_rt)));
    end

    // flush overrides everything so the redirect is never frozen
    assign bus.stall = ~bus.flush & (load_use | bus.e_hold);
    assign kill      = bus.flush | (~bus.e_hold & load_use);

    // ID/EX register: reset, bubble, hold, or load
    always_ff @(posedge clk or posedge clrn) begin
        if (clrn) begin
            bus.e_valid <= 1'b0;
            bus.e_wreg  <= 1'b0;
            bus.e_m2reg <= 1'b0;
            bus.e_wn    <= 5'd0;
            bus.e_a     <= '0;
            bus.e_b     <= '0;
            bus.e_imm   <= '0;
            bus.e_ctrl  <= CTRL_W'(0);
        end else if (kill) begin
            bus.e_valid <= 1'b0;
            bus.e_wreg  <= 1'b0;
            bus.e_m2reg <= 1'b0;
            bus.e_wn    <= 5'd0;
            bus.e_a     <= '0;
            bus.e_b     <= '0;
            bus.e_imm   <= '0;
            bus.e_ctrl  <= CTRL_W'(0);
        end else if (!bus.e_hold) begin
            bus.e_valid <= bus.d_valid;
            bus.e_wreg  <= bus.d_wreg & bus.d_valid;
            bus.e_m2reg <= bus.d_m2reg & bus.d_valid;
            bus.e_wn    <= bus.d_wn;
            bus.e_a     <= fwd_a;
            bus.e_b     <= fwd_b;
            bus.e_imm   <= bus.d_imm;
            bus.e_ctrl  <= bus.d_ctrl;
        end
    end

`ifdef IDEX_PERF_EN
    // saturating count of load-use bubbles and unflushed hold cycles
    always_ff @(posedge clk or posedge clrn) begin
        if (clrn) begin
            bus.bubble_cnt <= 32'd0;
            bus.hold_cnt   <= 32'd0;
        end else begin
            if (!bus.flush && !bus.e_hold && load_use && bus.bubble_cnt != 32'hFFFF_FFFF)
                bus.bubble_cnt <= bus.bubble_cnt + 32'd1;
            if (!bus.flush && bus.e_hold && bus.hold_cnt != 32'hFFFF_FFFF)
                bus.hold_cnt <= bus.hold_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_idex_operand_stage.sv
// Bench for idex_operand_stage: directed table, hold/reset sequences, random vs model.
module tb_idex_operand_stage;
    localparam int unsigned W      = 32;
    localparam int unsigned CTRL_W = 8;

    typedef struct {
        logic              d_valid;
        logic [4:0]        d_rs, d_rt;
        logic              d_uses_rs, d_uses_rt;
        logic [4:0]        d_wn;
        logic              d_wreg, d_m2reg;
        logic [W-1:0]      d_imm;
        logic [CTRL_W-1:0] d_ctrl;
        logic [W-1:0]      qa, qb, e_alu;
        logic [4:0]        m_wn;
        logic              m_wreg, m_m2reg;
        logic [W-1:0]      m_alu, m_mdata;
        logic [4:0]        w_wn;
        logic              w_we;
        logic [W-1:0]      w_d;
        logic              flush, e_hold;
    } in_t;

    typedef struct {
        logic              valid, wreg, m2reg;
        logic [4:0]        wn;
        logic [W-1:0]      a, b, imm;
        logic [CTRL_W-1:0] ctrl;
    } ex_t;

    typedef struct {
        in_t          in;
        logic         stall, valid, wreg;
        logic [W-1:0] a, b;
    } vec_t;

    logic clk = 1'b0;
    logic clrn = 1'b1;
    always #5 clk = ~clk;

    idex_operand_stage_if #(.W(W), .CTRL_W(CTRL_W)) bus ();
    idex_operand_stage #(.W(W), .CTRL_W(CTRL_W)) dut (.clk(clk), .clrn(clrn), .bus(bus));

    int   n_checks = 0;
    int   n_errors = 0;
    ex_t  mdl;
    logic [31:0] m_bubbles, m_holds;
    logic exp_stall, got_stall;
    logic [4:0] got_rna, got_rnb;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic in_t blank();
        in_t s;
        s = '{default: '0};
        return s;
    endfunction

    task automatic apply(input in_t s);
        bus.d_valid = s.d_valid;   bus.d_rs = s.d_rs;         bus.d_rt = s.d_rt;
        bus.d_uses_rs = s.d_uses_rs; bus.d_uses_rt = s.d_uses_rt;
        bus.d_wn = s.d_wn;         bus.d_wreg = s.d_wreg;     bus.d_m2reg = s.d_m2reg;
        bus.d_imm = s.d_imm;       bus.d_ctrl = s.d_ctrl;
        bus.qa = s.qa;             bus.qb = s.qb;             bus.e_alu = s.e_alu;
        bus.m_wn = s.m_wn;         bus.m_wreg = s.m_wreg;     bus.m_m2reg = s.m_m2reg;
        bus.m_alu = s.m_alu;       bus.m_mdata = s.m_mdata;
        bus.w_wn = s.w_wn;         bus.w_we = s.w_we;         bus.w_d = s.w_d;
        bus.flush = s.flush;       bus.e_hold = s.e_hold;
    endtask

    // newest writer of register r among EX, MEM, WB; r0 is hardwired zero
    function automatic logic [W-1:0] mdl_operand(input logic [4:0] r, input logic [W-1:0] q, input in_t s);
        logic         en  [3];
        logic [4:0]   wn  [3];
        logic [W-1:0] val [3];
        en[0] = mdl.valid && mdl.wreg && !mdl.m2reg; wn[0] = mdl.wn; val[0] = s.e_alu;
        en[1] = s.m_wreg; wn[1] = s.m_wn; val[1] = s.m_m2reg ? s.m_mdata : s.m_alu;
        en[2] = s.w_we;   wn[2] = s.w_wn; val[2] = s.w_d;
        if (r == 5'd0) return '0;
        for (int i = 0; i < 3; i++)
            if (en[i] && wn[i] == r) return val[i];
        return q;
    endfunction

    // one clock: apply at negedge, sample comb, advance model at posedge
    task automatic cycle(input in_t s);
        ex_t  nxt;
        logic lu;
        @(negedge clk);
        clrn = 1'b0;
        apply(s);
        #1;
        got_stall = bus.stall;
        got_rna   = bus.rna;
        got_rnb   = bus.rnb;
        lu = s.d_valid && mdl.valid && mdl.wreg && mdl.m2reg && mdl.wn != 5'd0 &&
             ((s.d_uses_rs && mdl.wn == s.d_rs) || (s.d_uses_rt && mdl.wn == s.d_rt));
        exp_stall = !s.flush && (lu || s.e_hold);
        if (s.flush || (!s.e_hold && lu)) nxt = '{default: '0};
        else if (s.e_hold)                nxt = mdl;
        else begin
            nxt.valid = s.d_valid;
            nxt.wreg  = s.d_wreg && s.d_valid;
            nxt.m2reg = s.d_m2reg && s.d_valid;
            nxt.wn    = s.d_wn;
            nxt.a     = mdl_operand(s.d_rs, s.qa, s);
            nxt.b     = mdl_operand(s.d_rt, s.qb, s);
            nxt.imm   = s.d_imm;
            nxt.ctrl  = s.d_ctrl;
        end
        if (!s.flush && s.e_hold)            m_holds++;
        else if (!s.flush && lu)             m_bubbles++;
        @(posedge clk);
        #1;
        mdl = nxt;
    endtask

    task automatic chk_ex(input string tag);
        chk({tag, ".e_valid"}, 64'(bus.e_valid), 64'(mdl.valid));
        chk({tag, ".e_wreg"},  64'(bus.e_wreg),  64'(mdl.wreg));
        chk({tag, ".e_m2reg"}, 64'(bus.e_m2reg), 64'(mdl.m2reg));
        chk({tag, ".e_wn"},    64'(bus.e_wn),    64'(mdl.wn));
        chk({tag, ".e_a"},     64'(bus.e_a),     64'(mdl.a));
        chk({tag, ".e_b"},     64'(bus.e_b),     64'(mdl.b));
        chk({tag, ".e_imm"},   64'(bus.e_imm),   64'(mdl.imm));
        chk({tag, ".e_ctrl"},  64'(bus.e_ctrl),  64'(mdl.ctrl));
    endtask

    function automatic in_t rand_in();
        in_t s;
        s.d_valid = ($urandom_range(0, 7) != 0);
        s.d_rs = 5'($urandom_range(0, 3)); s.d_rt = 5'($urandom_range(0, 3));
        s.d_uses_rs = 1'($urandom); s.d_uses_rt = 1'($urandom);
        s.d_wn = 5'($urandom_range(0, 3));
        s.d_wreg = 1'($urandom); s.d_m2reg = 1'($urandom);
        s.d_imm = W'($urandom); s.d_ctrl = CTRL_W'($urandom);
        s.qa = W'($urandom); s.qb = W'($urandom); s.e_alu = W'($urandom);
        s.m_wn = 5'($urandom_range(0, 3)); s.m_wreg = 1'($urandom); s.m_m2reg = 1'($urandom);
        s.m_alu = W'($urandom); s.m_mdata = W'($urandom);
        s.w_wn = 5'($urandom_range(0, 3)); s.w_we = 1'($urandom); s.w_d = W'($urandom);
        s.flush = ($urandom_range(0, 15) == 0);
        s.e_hold = ($urandom_range(0, 7) == 0);
        return s;
    endfunction

    // async reset with garbage inputs: clear is immediate, stall follows e_hold
    task automatic do_reset(input logic hold);
        in_t s;
        @(negedge clk);
        s = rand_in();
        s.flush = 1'b0;
        s.e_hold = hold;
        apply(s);
        clrn = 1'b1;
        #1;
        mdl = '{default: '0};
        m_bubbles = '0;
        m_holds = '0;
        chk_ex("reset");
        chk("reset.stall", 64'(bus.stall), 64'(hold));
`ifdef IDEX_PERF_EN
        chk("reset.bubble_cnt", 64'(bus.bubble_cnt), 64'd0);
        chk("reset.hold_cnt",   64'(bus.hold_cnt),   64'd0);
`endif
        @(posedge clk);
        #1;
        chk("reset.e_valid_edge", 64'(bus.e_valid), 64'd0);
    endtask

    vec_t vec [10];
    in_t  s;

    initial begin
        // directed table, run straight after reset
        s = blank(); s.d_valid = 1; s.d_wn = 5; s.d_wreg = 1; s.d_imm = 32'h100;
        s.d_ctrl = 8'h01; s.qa = 32'h44; s.qb = 32'h55;
        vec[0] = '{s, 1'b0, 1'b1, 1'b1, 32'h0, 32'h0};
        s.d_rs = 5; s.d_rt = 5; s.d_uses_rs = 1; s.d_uses_rt = 1; s.d_wn = 7;
        s.e_alu = 32'h11; s.m_wn = 5; s.m_wreg = 1; s.m_alu = 32'h22; s.m_mdata = 32'h99;
        s.w_wn = 5; s.w_we = 1; s.w_d = 32'h33;
        vec[1] = '{s, 1'b0, 1'b1, 1'b1, 32'h11, 32'h11};
        vec[2] = '{s, 1'b0, 1'b1, 1'b1, 32'h22, 32'h22};
        s.m_wreg = 0;
        vec[3] = '{s, 1'b0, 1'b1, 1'b1, 32'h33, 32'h33};
        s.w_we = 0; s.d_wn = 0; s.d_m2reg = 1;
        vec[4] = '{s, 1'b0, 1'b1, 1'b1, 32'h44, 32'h55};
        s = blank(); s.d_valid = 1; s.d_uses_rs = 1; s.d_uses_rt = 1; s.d_wn = 3;
        s.e_alu = 32'hFF; s.m_wreg = 1; s.m_m2reg = 1; s.m_mdata = 32'hFF; s.m_alu = 32'hFF;
        s.w_we = 1; s.w_d = 32'hFF;
        vec[5] = '{s, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0};
        s = blank(); s.d_valid = 1; s.d_wn = 8; s.d_wreg = 1; s.d_m2reg = 1;
        vec[6] = '{s, 1'b0, 1'b1, 1'b1, 32'h0, 32'h0};
        s = blank(); s.d_valid = 1; s.d_rt = 8; s.d_uses_rt = 1; s.d_wn = 9;
        s.d_wreg = 1; s.d_m2reg = 1; s.qb = 32'h1234;
        vec[7] = '{s, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0};
        s.m_wn = 8; s.m_wreg = 1; s.m_m2reg = 1; s.m_mdata = 32'hDEADBEEF; s.m_alu = 32'h5555;
        vec[8] = '{s, 1'b0, 1'b1, 1'b1, 32'h0, 32'hDEADBEEF};
        s = blank(); s.d_valid = 1; s.d_rs = 9; s.d_uses_rs = 1; s.d_wreg = 1;
        s.e_hold = 1; s.flush = 1;
        vec[9] = '{s, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0};

        do_reset(1'b1);
        do_reset(1'b0);
        for (int i = 0; i < 10; i++) begin
            cycle(vec[i].in);
            chk($sformatf("vec%0d.stall", i),   64'(got_stall),   64'(vec[i].stall));
            chk($sformatf("vec%0d.e_valid", i), 64'(bus.e_valid), 64'(vec[i].valid));
            chk($sformatf("vec%0d.e_wreg", i),  64'(bus.e_wreg),  64'(vec[i].wreg));
            chk($sformatf("vec%0d.e_a", i),     64'(bus.e_a),     64'(vec[i].a));
            chk($sformatf("vec%0d.e_b", i),     64'(bus.e_b),     64'(vec[i].b));
        end
`ifdef IDEX_PERF_EN
        chk("table.bubble_cnt", 64'(bus.bubble_cnt), 64'd1);
        chk("table.hold_cnt",   64'(bus.hold_cnt),   64'd0);
`endif

        // hold for 3 cycles with a changing decode, then reset mid-hold
        do_reset(1'b0);
        s = blank(); s.d_valid = 1; s.d_wn = 12; s.d_wreg = 1;
        s.d_imm = 32'hABC; s.d_ctrl = 8'h5A;
        cycle(s);
        chk("hold.load.e_wn", 64'(bus.e_wn), 64'd12);
        for (int i = 0; i < 3; i++) begin
            s = rand_in();
            s.flush = 0; s.e_hold = 1;
            cycle(s);
            chk($sformatf("hold%0d.stall", i),   64'(got_stall),   64'd1);
            chk($sformatf("hold%0d.e_valid", i), 64'(bus.e_valid), 64'd1);
            chk($sformatf("hold%0d.e_wreg", i),  64'(bus.e_wreg),  64'd1);
            chk($sformatf("hold%0d.e_wn", i),    64'(bus.e_wn),    64'd12);
            chk($sformatf("hold%0d.e_imm", i),   64'(bus.e_imm),   64'hABC);
            chk($sformatf("hold%0d.e_ctrl", i),  64'(bus.e_ctrl),  64'h5A);
        end
`ifdef IDEX_PERF_EN
        chk("hold.hold_cnt", 64'(bus.hold_cnt), 64'd3);
`endif
        do_reset(1'b1);

        // random traffic against the reference model
        for (int i = 0; i < 400; i++) begin
            s = rand_in();
            cycle(s);
            chk("rand.rna",   64'(got_rna),   64'(s.d_rs));
            chk("rand.rnb",   64'(got_rnb),   64'(s.d_rt));
            chk("rand.stall", 64'(got_stall), 64'(exp_stall));
            chk_ex("rand");
        end
`ifdef IDEX_PERF_EN
        chk("rand.bubble_cnt", 64'(bus.bubble_cnt), 64'(m_bubbles));
        chk("rand.hold_cnt",   64'(bus.hold_cnt),   64'(m_holds));
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/idex_operand_stage.md
# idex_operand_stage

Operand-fetch and ID/EX pipeline register of the 5-stage pipelined CPU. It sits between decode and the register file read ports, and drives the EX stage.
- Drives the register file read addresses.
- Resolves RAW hazards by forwarding from EX, MEM and WB, with WB forwarding covering the same-cycle register-file write.
- Detects load-use hazards and inserts a bubble.
- Latches operands and control into the EX stage, honouring hold and flush.

## Interface
Parameters:
- W, 32, datapath width.
- CTRL_W, 8, width of opaque decoded-control bundle passed to EX.

Ports:
- clk  in  1  clock, rising edge.
- clrn  in  1  reset, asynchronous, active-high.
- d_valid  in  1  decode holds a valid instruction.
- d_rs, d_rt  in  5  source register numbers.
- d_uses_rs, d_uses_rt  in  1  instruction actually reads rs / rt.
- d_wn  in  5  destination register.
- d_wreg, d_m2reg  in  1  writes register / is a load.
- d_imm  in  W  extended immediate.
- d_ctrl  in  CTRL_W  other decoded control.
- rna, rnb  out  5  register file read addresses, equal to d_rs and d_rt (combinational).
- qa, qb  in  W  register file read data.
- e_alu  in  W  EX result of the instruction currently held here.
- m_wn  in  5  MEM-stage destination register.
- m_wreg, m_m2reg  in  1  MEM-stage writes register / is a load.
- m_alu, m_mdata  in  W  MEM ALU result / load data.
- w_wn  in  5  WB destination, same signals as the register file write port.
- w_we  in  1  WB write enable.
- w_d  in  W  WB write data.
- flush  in  1  EX redirect (taken branch/jump); kill the decode instruction.
- e_hold  in  1  EX busy (multi-cycle op); freeze this register.
- stall  out  1  freeze PC and IF/ID (combinational).
- e_valid, e_wreg, e_m2reg  out  1  EX-stage valid / writes register / is a load.
- e_wn  out  5  EX-stage destination register.
- e_a, e_b, e_imm  out  W  EX-stage operands and immediate.
- e_ctrl  out  CTRL_W  EX-stage control bundle.

## Operation
- Forwarding for operand A (source d_rs), first match wins:
  - rs==0 gives 0.
  - e_valid&e_wreg&!e_m2reg&e_wn==rs gives e_alu.
  - m_wreg&m_wn==rs gives m_mdata if m_m2reg, else m_alu.
  - w_we&w_wn==rs gives w_d.
  - Otherwise qa.
- Operand B: same rules with d_rt, m/w paths and qb.
- Register 0 is never forwarded, even if a stage claims to write it.
- load_use = d_valid & e_valid & e_wreg & e_m2reg & e_wn!=0 & ((d_uses_rs & e_wn==d_rs) | (d_uses_rt & e_wn==d_rt)).
- stall = !flush & (load_use | e_hold).
- Register update at posedge clk, priority order:
  - clrn: all e_* outputs cleared.
  - flush: bubble (e_valid=0, e_wreg=0, e_m2reg=0, e_ctrl=0; data fields don't-care but cleared).
  - e_hold: all e_* retained.
  - load_use: bubble.
  - Otherwise load: e_valid=d_valid, e_wreg=d_wreg&d_valid, e_m2reg=d_m2reg&d_valid, forwarded A/B, d_imm, d_wn, d_ctrl.
- An invalid decode slot (d_valid=0) loads as a bubble: wreg/m2reg forced 0.

## Timing
- Reset value of every registered output: 0. stall after reset equals e_hold (e_valid=0, so load_use=0).
- Latency: decode to EX in 1 cycle. Load-use costs exactly 1 bubble; the MEM→ID m_mdata forward resolves the next cycle.
- WB forward removes the write-then-read hole: the register file updates only at the edge, while read is combinational.
- flush together with load_use or e_hold: flush wins, bubble inserted, stall=0 so the PC redirect proceeds.
- clrn asserted mid-hold or mid-stall: immediate clear, no retained state.

## Configuration
- IDEX_PERF_EN defined: adds outputs bubble_cnt (out 32) and hold_cnt (out 32).
  - bubble_cnt increments on every edge where a load_use bubble is inserted.
  - hold_cnt increments on every edge with e_hold & !flush.
  - Both saturate at 0xFFFFFFFF and are cleared by clrn.
- IDEX_PERF_EN undefined: counters and ports absent; behaviour otherwise identical.

## Test plan
- Reset: clrn=1 with arbitrary inputs → all e_* = 0, stall=e_hold; release → first valid decode appears on e_* after 1 edge.
- Forward priority: rs=5; EX holds non-load wn=5, e_alu=0x11; m_wn=5, m_alu=0x22; w_wn=5, w_d=0x33; qa=0x44 → e_a=0x11. Drop EX → 0x22; drop MEM → 0x33; drop WB → 0x44.
- Load-use: EX is load to r8, decode uses rt=8 → stall=1, next e_valid=0. Following cycle, m_m2reg with m_mdata=0xDEADBEEF → e_b=0xDEADBEEF, stall=0.
- r0: decode rs=0 while all stages write r0 with 0xFF → e_a=0, stall=0.
- Flush vs stall: load_use=1 and e_hold=1 with flush=1 → stall=0, next e_valid=0, e_wreg=0.
- Hold: e_hold=1 for 3 cycles with changing decode inputs → e_* constant, stall=1; with IDEX_PERF_EN, hold_cnt=3.
